ifetch_ctrl: RTL and testbench
==============================

// Module: ifetch_ctrl
// PURPOSE
//  Fetch sequencer for the instruction store (user code region + exception-handler region).
//  Owns the fetch PC and drives the word address into a 1-cycle synchronous-read instruction RAM.
//  Pairs each returned word with its PC and a valid flag for IF/ID.
//  Applies stall, branch/jump redirect, exception vectoring and ERET return with fixed priorities.
// PARAMETERS
//  RESET_PC    32'h0000_3000  first fetch address after reset
//  EXC_VEC     32'h0000_4180  exception/interrupt handler entry; first word of handler region
//  DELAY_SLOT  1              1: word in flight at redirect is kept (MIPS delay slot); 0: squashed
// PORTS
//  clk           in   1   clock
//  rst           in   1   synchronous, active-high reset
//  stall_i       in   1   hold fetch (load-use / mult-busy hazard)
//  redirect_i    in   1   branch/jump taken, from ID
//  redirect_pc_i in   32  branch/jump target
//  exc_i         in   1   exception/interrupt accepted, from CP0
//  eret_i        in   1   ERET executing
//  epc_i         in   32  CP0 EPC
//  imem_addr_o   out  30  word address [31:2] to instruction RAM
//  imem_rdata_i  in   32  RAM data; equals mem[addr presented previous cycle]
//  ir_o          out  32  fetched instruction
//  pc_o          out  32  PC of ir_o
//  valid_o       out  1   ir_o/pc_o carry a real instruction
//  adel_o        out  1   pc_o misaligned (pc_o[1:0]!=0); ir_o forced 32'h0
//  in_handler_o  out  1   pc_o >= EXC_VEC
// BEHAVIOUR
//  Regs: F (address presented), pc_q (address presented last cycle), valid_q, ir_hold, state.
//  imem_addr_o = F[31:2], always. pc_o = pc_q.
//  ir_o = adel_o ? 0 : (state==HOLD ? ir_hold : imem_rdata_i).
//  Reset (rst=1 at edge): F=RESET_PC, pc_q=RESET_PC, valid_q=0, ir_hold=0, state=BOOT.
//   All outputs are 0 except pc_o and imem_addr_o, which are RESET_PC-derived.
//   rst overrides everything, including mid-HOLD or mid-redirect.
//  FSM:
//   BOOT: the RESET_PC read is in flight; valid_o=0. Next: pc_q=F, F=F+4, valid_q=1 -> RUN.
//   RUN: event priority is exc_i > eret_i > stall_i > redirect_i > sequential.
//    sequential: pc_q=F, F=F+4, valid_q=1.
//    stall_i: ir_hold=imem_rdata_i; F, pc_q, valid_q hold -> HOLD.
//    redirect_i: pc_q=F, F=redirect_pc_i, valid_q=DELAY_SLOT. One bubble when DELAY_SLOT=0.
//    exc_i: pc_q=F, F=EXC_VEC, valid_q=0 (in-flight word always squashed).
//    eret_i: pc_q=F, F=epc_i, valid_q=0.
//   HOLD: outputs frozen (ir_o=ir_hold). RAM keeps reading mem[F].
//    stall_i=1: stay in HOLD. redirect_i is ignored while stalled; ID reasserts it after release.
//    stall_i=0: act as RUN sequential (pc_q=F, ir_o=imem_rdata_i=mem[F]) -> RUN.
//    exc_i/eret_i: act as in RUN -> RUN; they override the stall.
//  Latency: address to ir_o is 1 cycle. Taken exc/eret costs 1 bubble.
//  Width: F+4 is 32-bit and wraps modulo 2^32, with no flag.
//   Redirect/epc targets are loaded unmodified. When target[1:0]!=0, adel_o=1 for that slot.
//   RAM is addressed with target[31:2], and sequential fetch continues from target+4.
//  Simultaneous exc_i+eret_i: exc_i wins.
//  exc_i in BOOT: takes effect (F=EXC_VEC); valid_o stays 0.
//  in_handler_o compares pc_o unsigned against EXC_VEC.
// STRUCTURE
//  Shared package (mips_pkg): RESET_PC, EXC_VEC constants; fetch FSM state encoding
//   BOOT=2'd0, RUN=2'd1, HOLD=2'd2.
//  Single flat module; the next-PC mux is an always-comb block, not a sub-module.
//  The instruction RAM is external. This block never writes it.
// TESTING
//  1 Reset release, no events: valid_o low 1 cycle, then pc_o 0x3000, 0x3004, 0x3008 on successive cycles.
//    ir_o matches the preloaded RAM.
//  2 stall_i high 3 cycles while pc_o=0x3008: pc_o/ir_o frozen for all 3 cycles.
//    Release shows 0x300C with the correct word; no word is lost or duplicated.
//  3 redirect_i to 0x3100 with pc_o=0x3010, DELAY_SLOT=1: next pc_o 0x3014 valid, then 0x3100.
//    Repeat with DELAY_SLOT=0: 0x3014 appears with valid_o=0.
//  4 exc_i at pc 0x3020 concurrent with stall_i and redirect_i: one bubble, then pc_o 0x4180 valid.
//    in_handler_o=1.
//  5 eret_i with epc_i=0x3024 from handler: one bubble, then pc_o 0x3024, in_handler_o=0.
//    Separately, epc_i=0x3026 gives adel_o=1 and ir_o=0.
//  6 rst asserted during HOLD and during a redirect cycle: the next cycles reproduce scenario 1 exactly.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch constants and fetch FSM state encoding
package mips_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifetch_ctrl.sv
// rtl/ifetch_ctrl.sv - fetch PC sequencer pairing 1-cycle instruction RAM words with their PC
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC   = mips_pkg::RESET_PC,
    parameter logic [31:0] EXC_VEC    = mips_pkg::EXC_VEC,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,            // synchronous, active high
    input  logic        stall_i,        // hold fetch
    input  logic        redirect_i,     // branch/jump taken
    input  logic [31:0] redirect_pc_i,  // branch/jump target
    input  logic        exc_i,          // exception accepted
    input  logic        eret_i,         // ERET executing
    input  logic [31:0] epc_i,          // return address
    output logic [29:0] imem_addr_o,    // word address to instruction RAM
    input  logic [31:0] imem_rdata_i,   // mem[address presented last cycle]
    output logic [31:0] ir_o,           // fetched instruction
    output logic [31:0] pc_o,           // PC of ir_o
    output logic        valid_o,        // ir_o/pc_o carry a real instruction
    output logic        adel_o,         // pc_o misaligned, ir_o forced to zero
    output logic        in_handler_o    // pc_o inside handler region
);
    import mips_pkg::*;

    // f_q is the address being presented this cycle; pc_q is the address
    // presented last cycle, i.e. the PC of the word the RAM returns now.
    fetch_state_e state_q, state_d;
    logic [31:0]  f_q, f_d;
    logic [31:0]  pc_q, pc_d;
    logic         valid_q, valid_d;
    logic [31:0]  ir_hold_q, ir_hold_d;
    logic         misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BOOT;
            f_q       <= RESET_PC;
            pc_q      <= RESET_PC;
            valid_q   <= 1'b0;
            ir_hold_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            f_q       <= f_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            ir_hold_q <= ir_hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        f_d       = f_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        ir_hold_d = ir_hold_q;
        case (state_q)
            BOOT: begin
                pc_d    = f_q;
                state_d = RUN;
                if (exc_i) begin
                    f_d     = EXC_VEC;
                    valid_d = 1'b0;
                end else begin
                    f_d     = f_q + 32'd4;
                    valid_d = 1'b1;
                end
            end
            RUN, HOLD: begin
                state_d = RUN;
                if (exc_i) begin
                    // The word in flight is always dropped on vectoring.
                    pc_d    = f_q;
                    f_d     = EXC_VEC;
                    valid_d = 1'b0;
                end else if (eret_i) begin
                    pc_d    = f_q;
                    f_d     = epc_i;
                    valid_d = 1'b0;
                end else if (stall_i) begin
                    // Capture the word on the RAM port once on entry; while
                    // held, the RAM keeps returning mem[f_q], not mem[pc_q].
                    if (state_q == RUN) begin
                        ir_hold_d = imem_rdata_i;
                    end
                    state_d = HOLD;
                end else if (redirect_i && state_q == RUN) begin
                    pc_d    = f_q;
                    f_d     = redirect_pc_i;
                    valid_d = DELAY_SLOT;
                end else begin
                    pc_d    = f_q;
                    f_d     = f_q + 32'd4;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign misaligned = (pc_q[1:0] != 2'b00);

    always_comb begin
        imem_addr_o  = f_q[31:2];
        pc_o         = pc_q;
        valid_o      = valid_q;
        adel_o       = misaligned;
        in_handler_o = (pc_q >= EXC_VEC);
        // BOOT has no word of ours on the RAM port yet, so present zero.
        if (misaligned || state_q == BOOT) begin
            ir_o = 32'h0;
        end else if (state_q == HOLD) begin
            ir_o = ir_hold_q;
        end else begin
            ir_o = imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb/tb_ifetch_ctrl.sv - table-driven scoreboard bench for ifetch_ctrl
module tb_ifetch_ctrl;

    localparam logic [31:0] DC = 32'hFFFF_FFFF;

    typedef struct {
        bit          rst, stall, redir, exc, eret;
        logic [31:0] tgt, epc;
        bit          chk, boot, v1, v0, adel, inh;
        logic [31:0] pc, f;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, redir = 1'b0, exc = 1'b0, eret = 1'b0;
    logic [31:0] tgt = 32'h0, epc = 32'h0;

    logic [29:0] addr1, addr0;
    logic [31:0] rdata1, rdata0, ir1, ir0, pc1, pc0;
    logic        valid1, valid0, adel1, adel0, inh1, inh0;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [29:0] a);
        return {a, 2'b01} ^ 32'hC3A5_0F00;
    endfunction

    always_ff @(posedge clk) begin
        rdata1 <= ram_word(addr1);
        rdata0 <= ram_word(addr0);
    end

    ifetch_ctrl #(.DELAY_SLOT(1'b1)) u_ds1 (
        .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redir),
        .redirect_pc_i(tgt), .exc_i(exc), .eret_i(eret), .epc_i(epc),
        .imem_addr_o(addr1), .imem_rdata_i(rdata1), .ir_o(ir1), .pc_o(pc1),
        .valid_o(valid1), .adel_o(adel1), .in_handler_o(inh1)
    );

    ifetch_ctrl #(.DELAY_SLOT(1'b0)) u_ds0 (
        .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redir),
        .redirect_pc_i(tgt), .exc_i(exc), .eret_i(eret), .epc_i(epc),
        .imem_addr_o(addr0), .imem_rdata_i(rdata0), .ir_o(ir0), .pc_o(pc0),
        .valid_o(valid0), .adel_o(adel0), .in_handler_o(inh0)
    );

    function automatic vec_t row(input bit r, s, rd, e, er, input logic [31:0] t, ep,
                                 input bit c, b, v1, v0, ad, ih, input logic [31:0] p, f);
        vec_t v;
        v.rst = r; v.stall = s; v.redir = rd; v.exc = e; v.eret = er;
        v.tgt = t; v.epc = ep; v.chk = c; v.boot = b; v.v1 = v1; v.v0 = v0;
        v.adel = ad; v.inh = ih; v.pc = p; v.f = f;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        vec_t e;
        logic [31:0] exp_ir;
        @(posedge clk);
        #1;
        rst = v.rst; stall = v.stall; redir = v.redir; exc = v.exc; eret = v.eret;
        tgt = v.tgt; epc = v.epc;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        if (e.chk) begin
            exp_ir = (e.boot || e.adel) ? 32'h0 : ram_word(e.pc[31:2]);
            check("valid", idx, {31'h0, valid1}, {31'h0, e.v1});
            check("valid_ds0", idx, {31'h0, valid0}, {31'h0, e.v0});
            check("addr", idx, {2'b00, addr1}, {2'b00, e.f[31:2]});
            if (e.pc != DC) begin
                check("pc", idx, pc1, e.pc);
                check("pc_ds0", idx, pc0, e.pc);
                check("in_handler", idx, {31'h0, inh1}, {31'h0, e.inh});
            end
            if (e.v1 || e.boot) begin
                check("adel", idx, {31'h0, adel1}, {31'h0, e.adel});
                check("ir", idx, ir1, exp_ir);
            end
            if (e.v0 || e.boot) begin
                check("ir_ds0", idx, ir0, exp_ir);
            end
        end
    endtask

    initial begin
        //               rst s rd e er tgt           epc           chk b v1 v0 ad ih pc            f
        tbl.push_back(row(1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 0, DC,           DC));
        tbl.push_back(row(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 1, 0, 0, 0, 0, 32'h3000,     32'h3000));
        tbl.push_back(row(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 1, 0, 0, 32'h3000,     32'h3004));
        tbl.push_back(row(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 1, 0, 0, 32'h3004,     32'h3008));
        tbl.push_back(row(0, 1, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 1, 0, 0, 32'h3008,     32'h300C));
        tbl.push_back(row(0, 1, 1, 0, 0, 32'h5000,     32'h0,        1, 0, 1, 1, 0, 0, 32'h3008,     32'h300C));
        tbl.push_back(row(0, 1, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 1, 0, 0, 32'h3008,     32'h300C));
        tbl.push_back(row(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 1, 0, 0, 32'h3008,     32'h300C));
        tbl.push_back(row(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 1, 0, 0, 32'h300C,     32'h3010));
        tbl.push_back(row(0, 0, 1, 0, 0, 32'h3100,     32'h0,        1, 0, 1, 1, 0, 0, 32'h3010,     32'h3014));
        tbl.push_back(row(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 0, 0, 0, 32'h3014,     32'h3100));
        tbl.push_back(row(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 1, 0, 0, 32'h3100,     32'h3104));
        tbl.push_back(row(0, 0, 1, 0, 0, 32'h3020,     32'h0,        1, 0, 1, 1, 0, 0, 32'h3104,     32'h3108));
        tbl.push_back(row(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 0, 0, 0, 32'h3108,     32'h3020));
        tbl.push_back(row(0, 1, 1, 1, 0, 32'h5555_0000, 32'h0,       1, 0, 1, 1, 0, 0, 32'h3020,     32'h3024));
        tbl.push_back(row(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 0, 0, 0, 32'h3024,     32'h4180));
        tbl.push_back(row(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 1, 0, 1, 32'h4180,     32'h4184));
        tbl.push_back(row(0, 0, 0, 0, 1, 32'h0,        32'h3024,     1, 0, 1, 1, 0, 1, 32'h4184,     32'h4188));
        tbl.push_back(row(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 0, 0, 1, 32'h4188,     32'h3024));
        tbl.push_back(row(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 1, 0, 0, 32'h3024,     32'h3028));
        tbl.push_back(row(0, 0, 0, 0, 1, 32'h0,        32'h3026,     1, 0, 1, 1, 0, 0, 32'h3028,     32'h302C));
        tbl.push_back(row(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 0, 0, 0, 32'h302C,     32'h3026));
        tbl.push_back(row(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 1, 1, 0, 32'h3026,     32'h302A));
        tbl.push_back(row(0, 0, 0, 1, 1, 32'h0,        32'h3000,     1, 0, 1, 1, 1, 0, 32'h302A,     32'h302E));
        tbl.push_back(row(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 0, 0, 0, 32'h302E,     32'h4180));
        tbl.push_back(row(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 1, 0, 1, 32'h4180,     32'h4184));
        tbl.push_back(row(0, 1, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 1, 0, 1, 32'h4184,     32'h4188));
        tbl.push_back(row(0, 1, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 1, 0, 1, 32'h4184,     32'h4188));
        tbl.push_back(row(1, 1, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 1, 0, 1, 32'h4184,     32'h4188));
        tbl.push_back(row(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 1, 0, 0, 0, 0, 32'h3000,     32'h3000));
        tbl.push_back(row(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 1, 0, 0, 32'h3000,     32'h3004));
        tbl.push_back(row(0, 0, 1, 0, 0, 32'h3200,     32'h0,        1, 0, 1, 1, 0, 0, 32'h3004,     32'h3008));
        tbl.push_back(row(1, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 0, 0, 0, 32'h3008,     32'h3200));
        tbl.push_back(row(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 1, 0, 0, 0, 0, 32'h3000,     32'h3000));
        tbl.push_back(row(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 1, 0, 0, 32'h3000,     32'h3004));
        tbl.push_back(row(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 1, 0, 0, 32'h3004,     32'h3008));
        tbl.push_back(row(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 1, 0, 0, 32'h3008,     32'h300C));
        tbl.push_back(row(1, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 1, 0, 0, 32'h300C,     32'h3010));
        tbl.push_back(row(0, 0, 0, 1, 0, 32'h0,        32'h0,        1, 1, 0, 0, 0, 0, 32'h3000,     32'h3000));
        tbl.push_back(row(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 0, 0, 0, DC,           32'h4180));
        tbl.push_back(row(0, 0, 1, 0, 0, 32'hFFFF_FFFC, 32'h0,       1, 0, 1, 1, 0, 1, 32'h4180,     32'h4184));
        tbl.push_back(row(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 0, 0, 1, 32'h4184,     32'hFFFF_FFFC));
        tbl.push_back(row(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 1, 0, 1, 32'hFFFF_FFFC, 32'h0));
        tbl.push_back(row(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 1, 0, 0, 32'h0,        32'h4));

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], i);
        end

        // Exception arriving while held overrides the stall.
        run_vec(row(0, 1, 0, 0, 0, 32'h0, 32'h0, 1, 0, 1, 1, 0, 0, 32'h4,    32'h8),    100);
        run_vec(row(0, 1, 0, 1, 0, 32'h0, 32'h0, 1, 0, 1, 1, 0, 0, 32'h4,    32'h8),    101);
        run_vec(row(0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 0, 0, 32'h8,    32'h4180), 102);
        run_vec(row(0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 1, 1, 0, 1, 32'h4180, 32'h4184), 103);

        // ERET arriving while held, with a redirect also asserted.
        run_vec(row(0, 1, 0, 0, 0, 32'h0,    32'h0,    1, 0, 1, 1, 0, 1, 32'h4184, 32'h4188), 104);
        run_vec(row(0, 1, 1, 0, 1, 32'h6000, 32'h3040, 1, 0, 1, 1, 0, 1, 32'h4184, 32'h4188), 105);
        run_vec(row(0, 0, 0, 0, 0, 32'h0,    32'h0,    1, 0, 0, 0, 0, 1, 32'h4188, 32'h3040), 106);
        run_vec(row(0, 0, 0, 0, 0, 32'h0,    32'h0,    1, 0, 1, 1, 0, 0, 32'h3040, 32'h3044), 107);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
